// File: rtl/alu_pkg.sv
// Shared op-code definitions for the alu8 datapath and its arbiter front end.
package alu_pkg;

    typedef logic [2:0] fun_sel_t;

    localparam fun_sel_t FUN_AND = 3'b000;
    localparam fun_sel_t FUN_OR  = 3'b001;
    localparam fun_sel_t FUN_ADD = 3'b010;
    localparam fun_sel_t FUN_SUB = 3'b011;
    localparam fun_sel_t FUN_SLT = 3'b111;

    function automatic logic is_reserved(input fun_sel_t funSel);
        return (funSel == 3'b100) || (funSel == 3'b101) || (funSel == 3'b110);
    endfunction

endpackage

// File: rtl/alu8.sv
// 8-bit combinational ALU: AND/OR/ADD/SUB/unsigned SLT; reserved codes yield zero.
module alu8
    import alu_pkg::*;
(
    input  fun_sel_t    funSel,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [7:0]  result,
    output logic        zero
);

    always_comb begin
        result = '0;
        case (funSel)
            FUN_AND: result = a & b;
            FUN_OR:  result = a | b;
            FUN_ADD: result = a + b;
            FUN_SUB: result = a - b;
            FUN_SLT: result = {7'b0, (a < b)};
            default: result = '0;
        endcase
        zero = (result == 8'd0);
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past the last grant; pointer moves only on advance.
module rr_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned NREQ = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic                     advance,
    output logic [NREQ-1:0]          grant,
    output logic [$clog2(NREQ)-1:0]  grantIdx
);

    localparam int unsigned IDW = $clog2(NREQ);

    logic [IDW-1:0] last;
    logic           found;
    int unsigned    idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            last <= IDW'(NREQ - 1);
        end else if (advance) begin
            last <= grantIdx;
        end
    end

    always_comb begin
        grant    = '0;
        grantIdx = '0;
        found    = 1'b0;
        idx      = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (32'(last) + k) % NREQ;
            if (!found && req[idx]) begin
                found     = 1'b1;
                grant[idx] = 1'b1;
                grantIdx  = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one alu8 among NREQ requesters with round-robin arbitration and a single
// registered response stage tagged with the requester index.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     reqValid,
    output logic [NREQ-1:0]     reqReady,
    input  logic [3*NREQ-1:0]   reqFunSel,
    input  logic [8*NREQ-1:0]   reqA,
    input  logic [8*NREQ-1:0]   reqB,
    output logic                rspValid,
    input  logic                rspReady,
    output logic [7:0]          rspResult,
    output logic                rspZero,
    output logic                rspErr,
    output logic [IDW-1:0]      rspId,
    output logic [15:0]         opCount
);

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grantIdx;
    logic            canAccept;
    logic            accept;
    fun_sel_t        funSel;
    logic [7:0]      aluA;
    logic [7:0]      aluB;
    logic [7:0]      aluResult;
    logic            aluZero;

    assign canAccept = ~rspValid | rspReady;
    assign reqReady  = (rst || !canAccept) ? '0 : grant;
    assign accept    = |(reqValid & reqReady);

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk      (clk),
        .rst      (rst),
        .req      (reqValid),
        .advance  (accept),
        .grant    (grant),
        .grantIdx (grantIdx)
    );

    // grant is one-hot or zero, so the OR-free select below never has two hits
    always_comb begin
        funSel = '0;
        aluA   = '0;
        aluB   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                funSel = reqFunSel[3*i +: 3];
                aluA   = reqA[8*i +: 8];
                aluB   = reqB[8*i +: 8];
            end
        end
    end

    alu8 u_alu (
        .funSel (funSel),
        .a      (aluA),
        .b      (aluB),
        .result (aluResult),
        .zero   (aluZero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rspValid  <= 1'b0;
            rspResult <= '0;
            rspZero   <= 1'b0;
            rspErr    <= 1'b0;
            rspId     <= '0;
            opCount   <= '0;
        end else if (accept) begin
            rspValid  <= 1'b1;
            rspResult <= aluResult;
            rspZero   <= aluZero;
            rspErr    <= is_reserved(funSel);
            rspId     <= grantIdx;
            opCount   <= opCount + 16'd1;
        end else if (rspReady) begin
            rspValid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with NREQ=2.
module tb_alu_arbiter;

    localparam int unsigned NREQ = 2;
    localparam int unsigned IDW  = 1;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    reqValid;
    logic [NREQ-1:0]    reqReady;
    logic [3*NREQ-1:0]  reqFunSel;
    logic [8*NREQ-1:0]  reqA;
    logic [8*NREQ-1:0]  reqB;
    logic               rspValid;
    logic               rspReady;
    logic [7:0]         rspResult;
    logic               rspZero;
    logic               rspErr;
    logic [IDW-1:0]     rspId;
    logic [15:0]        opCount;

    int total  = 0;
    int passed = 0;

    alu_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .reqValid  (reqValid),
        .reqReady  (reqReady),
        .reqFunSel (reqFunSel),
        .reqA      (reqA),
        .reqB      (reqB),
        .rspValid  (rspValid),
        .rspReady  (rspReady),
        .rspResult (rspResult),
        .rspZero   (rspZero),
        .rspErr    (rspErr),
        .rspId     (rspId),
        .opCount   (opCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_req(input int i, input logic [2:0] f, input logic [7:0] a, input logic [7:0] b);
        reqValid[i]        = 1'b1;
        reqFunSel[3*i +: 3] = f;
        reqA[8*i +: 8]     = a;
        reqB[8*i +: 8]     = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op on requester i with rspReady=1, confirm the grant, clock it in.
    task automatic issue(input int i, input logic [2:0] f, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] expReady, input string tag);
        reqValid = '0;
        rspReady = 1'b1;
        set_req(i, f, a, b);
        #1;
        check({tag, "_ready"}, reqReady, expReady);
        tick();
        reqValid = '0;
    endtask

    initial begin
        rst       = 1'b1;
        reqValid  = 2'b01;
        reqFunSel = '0;
        reqA      = '0;
        reqB      = '0;
        rspReady  = 1'b0;

        // Reset for two cycles; reqReady forced low even with a valid request.
        tick();
        check("rst_ready", reqReady, 2'b00);
        tick();
        check("rst_valid", rspValid, 0);
        check("rst_result", rspResult, 0);
        check("rst_zero", rspZero, 0);
        check("rst_err", rspErr, 0);
        check("rst_id", rspId, 0);
        check("rst_count", opCount, 0);
        rst = 1'b0;

        // Single ADD 200+100 wraps to 44.
        issue(0, 3'b010, 8'd200, 8'd100, 2'b01, "add");
        check("add_valid", rspValid, 1);
        check("add_result", rspResult, 44);
        check("add_zero", rspZero, 0);
        check("add_err", rspErr, 0);
        check("add_id", rspId, 0);
        check("add_count", opCount, 1);

        // Round robin from a fresh reset: grants 0,1,0,1.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rspReady = 1'b1;
        set_req(0, 3'b011, 8'd5, 8'd5);
        set_req(1, 3'b001, 8'd0, 8'd0);
        for (int n = 0; n < 4; n++) begin
            #1;
            check("rr_ready", reqReady, (n % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            check("rr_id", rspId, n % 2);
            check("rr_zero", rspZero, 1);
        end
        check("rr_count", opCount, 4);

        // Drain, then backpressure with requester 1's AND held in the register.
        reqValid = '0;
        tick();
        check("drain_valid", rspValid, 0);
        rspReady = 1'b0;
        set_req(1, 3'b000, 8'hF0, 8'h3C);
        #1;
        check("bp_accept_ready", reqReady, 2'b10);
        tick();
        reqValid = '0;
        set_req(0, 3'b010, 8'd1, 8'd2);
        for (int n = 0; n < 3; n++) begin
            #1;
            check("bp_ready", reqReady, 2'b00);
            check("bp_result", rspResult, 8'h30);
            check("bp_id", rspId, 1);
            check("bp_valid", rspValid, 1);
            tick();
        end
        rspReady = 1'b1;
        #1;
        check("bp_release_ready", reqReady, 2'b01);
        tick();
        reqValid = '0;
        check("bp_next_result", rspResult, 3);
        check("bp_next_id", rspId, 0);

        // Reserved op and unsigned SLT.
        issue(1, 3'b101, 8'd7, 8'd9, 2'b10, "rsv");
        check("rsv_result", rspResult, 0);
        check("rsv_zero", rspZero, 1);
        check("rsv_err", rspErr, 1);
        issue(0, 3'b111, 8'd3, 8'd200, 2'b01, "slt_lt");
        check("slt_lt_result", rspResult, 1);
        check("slt_lt_err", rspErr, 0);
        issue(1, 3'b111, 8'd200, 8'd3, 2'b10, "slt_ge");
        check("slt_ge_result", rspResult, 0);
        check("slt_ge_zero", rspZero, 1);

        // Reset while a response is held.
        rspReady = 1'b0;
        set_req(0, 3'b000, 8'hFF, 8'hFF);
        tick();
        reqValid = '0;
        check("mid_full", rspValid, 1);
        rst = 1'b1;
        set_req(1, 3'b000, 8'h01, 8'h01);
        #1;
        check("mid_rst_ready", reqReady, 2'b00);
        tick();
        check("mid_rst_valid", rspValid, 0);
        check("mid_rst_count", opCount, 0);
        rst = 1'b0;
        rspReady = 1'b1;
        set_req(0, 3'b001, 8'h0A, 8'h50);
        #1;
        check("mid_after_ready", reqReady, 2'b01);
        tick();
        reqValid = '0;
        check("mid_after_id", rspId, 0);
        check("mid_after_result", rspResult, 8'h5A);

        // opCount wraps after 65536 accepts.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rspReady = 1'b1;
        set_req(0, 3'b010, 8'd1, 8'd1);
        repeat (65535) @(posedge clk);
        #1;
        check("wrap_max", opCount, 16'hFFFF);
        tick();
        check("wrap_zero", opCount, 0);
        reqValid = '0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
